// File: rtl/ads5296_tx_emulator.sv
// ADS5296 LVDS transmit emulator: per-channel test patterns sent as two 5-bit beats per sample.
// Optional PRBS9 pattern (mode 4) is compiled only when ADS5296_EMU_PRBS_EN is defined.
module ads5296_tx_emulator #(
  parameter int         G_NUM_CH    = 16,
  parameter logic [8:0] G_PRBS_SEED = 9'h1FF
) (
  input  logic                    sclk2_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [2:0]              mode,
  input  logic [9:0]              fixed_val,
  input  logic [3:0]              slip,
  output logic [5*G_NUM_CH-1:0]   tx_word,
  output logic                    fclk_pat,
  output logic [10*G_NUM_CH-1:0]  sample_out,
  output logic                    sample_valid,
  output logic                    sync_out
);

  // state     | meaning
  // PH_FIRST  | next beat starts a new sample (upper half, frame clock high)
  // PH_SECOND | next beat sends the lower half of the held sample
  typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_t;

  localparam int W_TX = 5 * G_NUM_CH;
  localparam int W_S  = 10 * G_NUM_CH;

  phase_t           phase;
  logic             sync_r;
  logic             start;
  logic [9:0]       cnt;
  logic [9:0]       cnt_use;
  logic [9:0]       prbs_word;
  logic [W_S-1:0]   s_next;
  logic [W_S-1:0]   rot_next;
  logic [W_S-1:0]   rot_held;
  logic [W_TX-1:0]  tx_hi;
  logic [W_TX-1:0]  tx_lo;

  if (G_PRBS_SEED == 9'd0) begin : g_bad_seed
    $error("G_PRBS_SEED must be non-zero");
  end

  function automatic logic [9:0] rot10(input logic [9:0] v, input logic [3:0] sl);
    logic [19:0] d;
    d = {v, v} << sl;
    return (sl >= 4'd10) ? v : d[19:10];
  endfunction

  // A sync edge restarts the pattern immediately, whatever the current phase.
  assign start   = sync & ~sync_r;
  assign cnt_use = start ? 10'd0 : cnt;

`ifdef ADS5296_EMU_PRBS_EN
  logic [8:0] prbs;
  logic [8:0] prbs_use;

  assign prbs_use  = start ? G_PRBS_SEED : prbs;
  assign prbs_word = {1'b0, prbs_use};

  always_ff @(posedge sclk2_in) begin
    if (rst) begin
      prbs <= G_PRBS_SEED;
    end else if (en && (start || phase == PH_FIRST)) begin
      prbs <= {prbs_use[7:0], prbs_use[8] ^ prbs_use[4]};
    end
  end
`else
  assign prbs_word = 10'd0;
`endif

  always_comb begin
    s_next   = '0;
    rot_next = '0;
    rot_held = '0;
    tx_hi    = '0;
    tx_lo    = '0;
    for (int c = 0; c < G_NUM_CH; c++) begin
      case (mode)
        3'd1:    s_next[10*c +: 10] = fixed_val;
        3'd2:    s_next[10*c +: 10] = cnt_use + 10'(c);
        3'd3:    s_next[10*c +: 10] = cnt_use[0] ? 10'h2AA : 10'h155;
        3'd4:    s_next[10*c +: 10] = prbs_word;
        3'd5:    s_next[10*c +: 10] = 10'h3E0;
        default: s_next[10*c +: 10] = 10'd0;
      endcase
      rot_next[10*c +: 10] = rot10(s_next[10*c +: 10], slip);
      rot_held[10*c +: 10] = rot10(sample_out[10*c +: 10], slip);
      tx_hi[5*c +: 5]      = rot_next[10*c + 5 +: 5];
      tx_lo[5*c +: 5]      = rot_held[10*c +: 5];
    end
  end

  always_ff @(posedge sclk2_in) begin
    if (rst) begin
      tx_word      <= '0;
      fclk_pat     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sync_out     <= 1'b0;
      phase        <= PH_FIRST;
      cnt          <= 10'd0;
      sync_r       <= 1'b0;
    end else begin
      sync_r <= sync;
      if (!en) begin
        tx_word      <= '0;
        fclk_pat     <= 1'b0;
        sample_valid <= 1'b0;
        sync_out     <= 1'b0;
        phase        <= PH_FIRST;
      end else if (start || phase == PH_FIRST) begin
        tx_word      <= tx_hi;
        fclk_pat     <= 1'b1;
        sample_valid <= 1'b1;
        sync_out     <= start;
        sample_out   <= s_next;
        cnt          <= cnt_use + 10'd1;
        phase        <= PH_SECOND;
      end else begin
        tx_word      <= tx_lo;
        fclk_pat     <= 1'b0;
        sample_valid <= 1'b0;
        sync_out     <= 1'b0;
        phase        <= PH_FIRST;
      end
    end
  end

endmodule

// File: tb/tb_ads5296_tx_emulator.sv
// Self-checking bench for ads5296_tx_emulator: sample-level reference model plus directed literal checks.
module tb_ads5296_tx_emulator;

  localparam int         NCH  = 4;
  localparam logic [8:0] SEED = 9'h1FF;

  logic             sclk2_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic [2:0]       mode = 3'd2;
  logic [9:0]       fixed_val = 10'd0;
  logic [3:0]       slip = 4'd0;
  logic [5*NCH-1:0] tx_word;
  logic             fclk_pat;
  logic [10*NCH-1:0] sample_out;
  logic             sample_valid;
  logic             sync_out;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [5*NCH-1:0]  e_tx = '0;
  logic [10*NCH-1:0] e_sample = '0;
  logic              e_fclk = 1'b0;
  logic              e_valid = 1'b0;
  logic              e_sync = 1'b0;
  int                m_cnt = 0;
  bit                m_mid = 1'b0;
  bit                m_sq = 1'b0;
  wire               m_start = sync && !m_sq;

  ads5296_tx_emulator #(.G_NUM_CH(NCH), .G_PRBS_SEED(SEED)) dut (
    .sclk2_in(sclk2_in), .rst(rst), .en(en), .sync(sync), .mode(mode),
    .fixed_val(fixed_val), .slip(slip), .tx_word(tx_word), .fclk_pat(fclk_pat),
    .sample_out(sample_out), .sample_valid(sample_valid), .sync_out(sync_out)
  );

  always #5 sclk2_in = ~sclk2_in;

  function automatic int prbs_val(input int n);
    logic [8:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = {s[7:0], s[8] ^ s[4]};
    return int'(s);
  endfunction

  // n = number of samples emitted since the last restart (reset or sync edge)
  function automatic logic [10*NCH-1:0] samples_of(input logic [2:0] md, input logic [9:0] fv, input int n);
    logic [10*NCH-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      case (md)
        3'd1: v = int'(fv);
        3'd2: v = (n + c) % 1024;
        3'd3: v = (n % 2 == 0) ? 'h155 : 'h2AA;
`ifdef ADS5296_EMU_PRBS_EN
        3'd4: v = prbs_val(n);
`endif
        3'd5: v = 'h3E0;
        default: v = 0;
      endcase
      r[10*c +: 10] = 10'(v);
    end
    return r;
  endfunction

  function automatic logic [9:0] rot10(input logic [9:0] v, input int sl);
    logic [9:0] r;
    if (sl >= 10) return v;
    r = '0;
    for (int i = 0; i < 10; i++) r[(i + sl) % 10] = v[i];
    return r;
  endfunction

  function automatic logic [5*NCH-1:0] tx_of(input logic [10*NCH-1:0] s, input int sl, input bit hi);
    logic [5*NCH-1:0] t;
    logic [9:0] r;
    t = '0;
    for (int c = 0; c < NCH; c++) begin
      r = rot10(s[10*c +: 10], sl);
      t[5*c +: 5] = hi ? r[9:5] : r[4:0];
    end
    return t;
  endfunction

  always @(posedge sclk2_in) begin
    if (rst) begin
      e_tx <= '0; e_sample <= '0; e_fclk <= 1'b0; e_valid <= 1'b0; e_sync <= 1'b0;
      m_cnt <= 0; m_mid <= 1'b0; m_sq <= 1'b0;
    end else begin
      m_sq <= sync;
      if (!en) begin
        e_tx <= '0; e_fclk <= 1'b0; e_valid <= 1'b0; e_sync <= 1'b0; m_mid <= 1'b0;
      end else if (m_start || !m_mid) begin
        e_sample <= samples_of(mode, fixed_val, m_start ? 0 : m_cnt);
        e_tx     <= tx_of(samples_of(mode, fixed_val, m_start ? 0 : m_cnt), int'(slip), 1'b1);
        e_fclk   <= 1'b1; e_valid <= 1'b1; e_sync <= m_start;
        m_cnt    <= (m_start ? 0 : m_cnt) + 1;
        m_mid    <= 1'b1;
      end else begin
        e_tx <= tx_of(e_sample, int'(slip), 1'b0);
        e_fclk <= 1'b0; e_valid <= 1'b0; e_sync <= 1'b0; m_mid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sclk2_in) begin
    if (chk_en) begin
      chk("model_tx_word", 64'(tx_word), 64'(e_tx));
      chk("model_fclk_pat", 64'(fclk_pat), 64'(e_fclk));
      chk("model_sample_out", 64'(sample_out), 64'(e_sample));
      chk("model_sample_valid", 64'(sample_valid), 64'(e_valid));
      chk("model_sync_out", 64'(sync_out), 64'(e_sync));
    end
  end

  task automatic tick();
    @(negedge sclk2_in);
  endtask

  initial begin
    bit found;
    tick;
    chk_en = 1'b1;
    tick;
    chk("rst_tx", 64'(tx_word), 0);
    chk("rst_sample", 64'(sample_out), 0);
    chk("rst_fclk", 64'(fclk_pat), 0);

    // ramp straight out of reset
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("ramp_ch0", 64'(sample_out[9:0]), 64'(i));
      chk("ramp_ch3", 64'(sample_out[39:30]), 64'(i + 3));
      chk("ramp_fclk_hi", 64'(fclk_pat), 1);
      chk("ramp_tx_hi", 64'(tx_word[4:0]), 0);
      tick;
      chk("ramp_fclk_lo", 64'(fclk_pat), 0);
      chk("ramp_tx_lo", 64'(tx_word[4:0]), 64'(i));
    end

    // fixed value with rotation, then a mid-sample change
    mode = 3'd1; fixed_val = 10'h201; slip = 4'd1;
    tick;
    chk("fixed_sample", 64'(sample_out[9:0]), 64'h201);
    chk("fixed_beat0", 64'(tx_word[4:0]), 64'h00);
    tick;
    chk("fixed_beat1", 64'(tx_word[4:0]), 64'h03);
    tick;
    fixed_val = 10'h0F0; slip = 4'd2;
    tick;
    chk("midchange_beat1", 64'(tx_word[4:0]), 64'h06);
    chk("midchange_held", 64'(sample_out[9:0]), 64'h201);
    tick;
    chk("midchange_next", 64'(sample_out[9:0]), 64'h0F0);
    chk("midchange_tx", 64'(tx_word[4:0]), 64'h1E);
    slip = 4'd12;
    tick;
    chk("slip_ge10", 64'(tx_word[4:0]), 64'h10);

    slip = 4'd0; mode = 3'd3;
    repeat (4) tick;
    mode = 3'd5;
    tick;
    chk("frame_ch2", 64'(sample_out[29:20]), 64'h3E0);
    chk("frame_tx_ch2", 64'(tx_word[14:10]), 64'h1F);
    tick;
    mode = 3'd6;
    repeat (2) tick;

    // sync restart mid-sample at counter 37
    mode = 3'd2; sync = 1'b1;
    tick;
    chk("sync1_out", 64'(sync_out), 1);
    chk("sync1_ch0", 64'(sample_out[9:0]), 0);
    sync = 1'b0;
    tick;
    for (int i = 1; i <= 35; i++) begin
      tick; tick;
    end
    tick;
    chk("pre_sync_ch0", 64'(sample_out[9:0]), 36);
    sync = 1'b1;
    tick;
    chk("sync2_out", 64'(sync_out), 1);
    chk("sync2_fclk", 64'(fclk_pat), 1);
    chk("sync2_ch0", 64'(sample_out[9:0]), 0);
    chk("sync2_ch1", 64'(sample_out[19:10]), 1);
    sync = 1'b0;
    tick;
    chk("sync2_beat1_fclk", 64'(fclk_pat), 0);

    // en dropped mid-sample for 3 cycles
    tick;
    chk("pre_drop_ch0", 64'(sample_out[9:0]), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("drop_tx", 64'(tx_word), 0);
      chk("drop_fclk", 64'(fclk_pat), 0);
      chk("drop_hold", 64'(sample_out[9:0]), 1);
    end
    en = 1'b1;
    tick;
    chk("reen_fclk", 64'(fclk_pat), 1);
    chk("reen_ch0", 64'(sample_out[9:0]), 2);

    // counter wrap
    found = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      tick;
      if (sample_valid && sample_out[9:0] == 10'd1023) begin
        found = 1'b1;
        break;
      end
    end
    chk("wrap_reached", 64'(found), 1);
    chk("wrap_ch1_at_1023", 64'(sample_out[19:10]), 0);
    tick; tick;
    chk("wrap_ch0", 64'(sample_out[9:0]), 0);
    chk("wrap_ch1", 64'(sample_out[19:10]), 1);

    // PRBS restarted by sync
    mode = 3'd4; sync = 1'b1;
    tick;
`ifdef ADS5296_EMU_PRBS_EN
    chk("prbs0", 64'(sample_out[9:0]), 64'h1FF);
`else
    chk("prbs0_off", 64'(sample_out[9:0]), 0);
`endif
    sync = 1'b0;
    tick; tick;
`ifdef ADS5296_EMU_PRBS_EN
    chk("prbs1", 64'(sample_out[39:30]), 64'h1FE);
`else
    chk("prbs1_off", 64'(sample_out[39:30]), 0);
`endif
    tick; tick;
`ifdef ADS5296_EMU_PRBS_EN
    chk("prbs2", 64'(sample_out[9:0]), 64'h1FC);
`else
    chk("prbs2_off", 64'(sample_out[9:0]), 0);
`endif

    // sync edge coincident with reset is discarded
    mode = 3'd2; rst = 1'b1; sync = 1'b1;
    tick;
    chk("rst2_sync_out", 64'(sync_out), 0);
    chk("rst2_sample", 64'(sample_out), 0);
    rst = 1'b0; sync = 1'b0;
    tick;
    chk("post_rst_sync_out", 64'(sync_out), 0);
    chk("post_rst_ch0", 64'(sample_out[9:0]), 0);
    chk("post_rst_fclk", 64'(fclk_pat), 1);
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
